// File: rtl/multdiv_sequencer_if.sv
// Bundle between the execute stage / multdiv unit / writeback and the sequencer.
// master: pipeline side (instruction, operands, unit result, writeback ownership)
// slave : sequencer side (unit start pulses, latched operands, stall, writeback)
interface multdiv_sequencer_if;
  logic [31:0] DX_IR;
  logic [31:0] operandA;
  logic [31:0] operandB;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        pipelineWE;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] mdA;
  logic [31:0] mdB;
  logic        stall;
  logic        wbEnable;
  logic [4:0]  wbReg;
  logic [31:0] wbData;
  logic        busy;

  modport master (
    output DX_IR, operandA, operandB, data_result, data_exception, data_resultRDY, pipelineWE,
    input  ctrl_MULT, ctrl_DIV, mdA, mdB, stall, wbEnable, wbReg, wbData, busy
  );

  modport slave (
    input  DX_IR, operandA, operandB, data_result, data_exception, data_resultRDY, pipelineWE,
    output ctrl_MULT, ctrl_DIV, mdA, mdB, stall, wbEnable, wbReg, wbData, busy
  );
endinterface

// File: rtl/multdiv_sequencer.sv
// Multi-cycle mult/div sequencer: detects a mult/div in X, freezes F/D/X,
// starts the unit, waits for its result (with a 64-cycle timeout) and writes
// the result or an exception code into the register file when the pipeline
// writeback stage leaves the write port free.
// Ports: clock, reset (sync, active-high); md_bus (slave modport) carries the
// instruction/operands, unit handshake, stall and writeback signals.
module multdiv_sequencer (
  input  logic                 clock,
  input  logic                 reset,
  multdiv_sequencer_if.slave   md_bus
);
  localparam int unsigned XLEN = 32;
  localparam int unsigned REGW = 5;
  localparam int unsigned CNTW = 6;

  localparam logic [4:0]      OPC_ALU     = 5'b00000;
  localparam logic [4:0]      ALU_MULT    = 5'b00110;
  localparam logic [4:0]      ALU_DIV     = 5'b00111;
  localparam logic [REGW-1:0] EXC_REG     = REGW'(30);
  localparam logic [XLEN-1:0] EXC_MULT    = XLEN'(4);
  localparam logic [XLEN-1:0] EXC_DIV     = XLEN'(5);
  localparam logic [XLEN-1:0] EXC_TIMEOUT = XLEN'(6);
  localparam logic [CNTW-1:0] CNT_MAX     = '1;

  typedef enum logic [1:0] {IDLE, START, BUSY, DONE} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] md_a_q, md_a_d, md_b_q, md_b_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [REGW-1:0] rd_q, rd_d;
  logic            is_div_q, is_div_d;
  logic            exc_q, exc_d;
  logic            timeout_q, timeout_d;
  logic [CNTW-1:0] cnt_q, cnt_d;

  logic [4:0]      opcode, aluop;
  logic            is_md;
  logic            unused_ir_bits;
  logic            stall_c, ctrl_mult_c, ctrl_div_c, wb_en_c, wb_suppress_c;
  logic [REGW-1:0] wb_reg_c;
  logic [XLEN-1:0] wb_data_c;

  // Instruction decode
  assign opcode         = md_bus.DX_IR[31:27];
  assign aluop          = md_bus.DX_IR[6:2];
  assign is_md          = (opcode == OPC_ALU) && ((aluop == ALU_MULT) || (aluop == ALU_DIV));
  // Instruction fields the sequencer does not decode
  assign unused_ir_bits = ^{md_bus.DX_IR[21:7], md_bus.DX_IR[1:0]};

  // Writeback target/data from the latched completion status
  always_comb begin
    wb_reg_c      = rd_q;
    wb_data_c     = result_q;
    wb_suppress_c = 1'b0;
    if (timeout_q) begin
      wb_reg_c  = EXC_REG;
      wb_data_c = EXC_TIMEOUT;
    end else if (exc_q) begin
      wb_reg_c  = EXC_REG;
      wb_data_c = is_div_q ? EXC_DIV : EXC_MULT;
    end else begin
      // r0 is hardwired: retire silently but keep the same timing
      wb_suppress_c = (rd_q == '0);
    end
  end

  // Next-state and control outputs
  always_comb begin
    state_d     = state_q;
    md_a_d      = md_a_q;
    md_b_d      = md_b_q;
    result_d    = result_q;
    rd_d        = rd_q;
    is_div_d    = is_div_q;
    exc_d       = exc_q;
    timeout_d   = timeout_q;
    cnt_d       = cnt_q;
    stall_c     = 1'b0;
    ctrl_mult_c = 1'b0;
    ctrl_div_c  = 1'b0;
    wb_en_c     = 1'b0;
    case (state_q)
      IDLE: begin
        if (is_md) begin
          stall_c  = 1'b1;
          md_a_d   = md_bus.operandA;
          md_b_d   = md_bus.operandB;
          rd_d     = md_bus.DX_IR[26:22];
          is_div_d = (aluop == ALU_DIV);
          state_d  = START;
        end
      end
      START: begin
        // Unit sees exactly one start pulse; a stale ready here is ignored
        stall_c     = 1'b1;
        ctrl_mult_c = ~is_div_q;
        ctrl_div_c  = is_div_q;
        cnt_d       = '0;
        state_d     = BUSY;
      end
      BUSY: begin
        stall_c = 1'b1;
        cnt_d   = cnt_q + CNTW'(1);
        if (md_bus.data_resultRDY) begin
          result_d  = md_bus.data_result;
          exc_d     = md_bus.data_exception;
          timeout_d = 1'b0;
          state_d   = DONE;
        end else if (cnt_q == CNT_MAX) begin
          exc_d     = 1'b0;
          timeout_d = 1'b1;
          state_d   = DONE;
        end
      end
      DONE: begin
        // Pipeline writeback owns the port; releasing stall in the write
        // cycle lets DX advance so the instruction is not re-issued.
        if (md_bus.pipelineWE) begin
          stall_c = 1'b1;
        end else begin
          wb_en_c = ~wb_suppress_c;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      md_a_q    <= '0;
      md_b_q    <= '0;
      result_q  <= '0;
      rd_q      <= '0;
      is_div_q  <= 1'b0;
      exc_q     <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      md_a_q    <= md_a_d;
      md_b_q    <= md_b_d;
      result_q  <= result_d;
      rd_q      <= rd_d;
      is_div_q  <= is_div_d;
      exc_q     <= exc_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
    end
  end

  assign md_bus.ctrl_MULT = ctrl_mult_c;
  assign md_bus.ctrl_DIV  = ctrl_div_c;
  assign md_bus.mdA       = md_a_q;
  assign md_bus.mdB       = md_b_q;
  assign md_bus.stall     = stall_c;
  assign md_bus.wbEnable  = wb_en_c;
  assign md_bus.wbReg     = wb_reg_c;
  assign md_bus.wbData    = wb_data_c;
  assign md_bus.busy      = (state_q != IDLE);
endmodule

// File: doc/multdiv_sequencer.md
MULTDIV_SEQUENCER -- requirements
Module: multdiv_sequencer

Interface
REQ-001 SHALL have port clock  input  1  rising-edge clock for all state.
REQ-002 SHALL have port reset  input  1  synchronous, active-high; sampled on the rising edge of clock.
REQ-003 SHALL have port DX_IR  input  32  execute-stage instruction; opcode [31:27], rd [26:22], aluop [6:2].
REQ-004 SHALL have port operandA, operandB  input  32 each  execute-stage source values.
REQ-005 SHALL have port data_result  input  32  multdiv unit result.
REQ-006 SHALL have port data_exception  input  1  multdiv unit exception flag.
REQ-007 SHALL have port data_resultRDY  input  1  multdiv unit completion.
REQ-008 SHALL have port pipelineWE  input  1  pipeline writeback stage owns the register-file write port this cycle.
REQ-009 SHALL have port ctrl_MULT, ctrl_DIV  output  1 each  one-cycle start pulses to the unit.
REQ-010 SHALL have port mdA, mdB  output  32 each  latched operands to the unit.
REQ-011 SHALL have port stall  output  1  freeze F/D/X pipeline registers.
REQ-012 SHALL have port wbEnable  output  1  sequencer write to the register file.
REQ-013 SHALL have port wbReg  output  5  sequencer write destination.
REQ-014 SHALL have port wbData  output  32  sequencer write data.
REQ-015 SHALL have port busy  output  1  state != IDLE.

Function
REQ-016 SHALL decode the issue condition isMD = (DX_IR[31:27]==00000) && (DX_IR[6:2]==00110 (mult) or 00111 (div)).
REQ-017 SHALL implement FSM states IDLE, START, BUSY and DONE.
REQ-018 SHALL, in IDLE with isMD, assert stall combinationally, latch operandA/B into mdA/mdB, latch rd and op type, and go to START.
REQ-019 SHALL, in IDLE without isMD, remain in IDLE with stall=0.
REQ-020 SHALL, in START, assert ctrl_MULT or ctrl_DIV (per the latched op) for exactly one cycle, clear the 6-bit cycle counter, go to BUSY, and ignore data_resultRDY.
REQ-021 SHALL, in BUSY, increment the counter by 1 per cycle.
REQ-022 SHALL, in BUSY on data_resultRDY=1, latch data_result and data_exception and go to DONE.
REQ-023 SHALL, in BUSY with the counter at 63 and no data_resultRDY, go to DONE with a timeout flag set.
REQ-024 SHALL, when both data_resultRDY and counter==63 occur in BUSY, give data_resultRDY priority.
REQ-025 SHALL, in DONE with pipelineWE=1, hold state with stall=1 and wbEnable=0; the pipeline has write-port priority.
REQ-026 SHALL, in DONE with pipelineWE=0, perform the write cycle: wbEnable=1, stall=0, next state IDLE.
REQ-027 SHALL, because stall=0 in the write cycle, let DX advance on that edge, so the retired instruction is never re-issued.
REQ-028 SHALL select write data as follows: normal result gives wbReg=latched rd, wbData=result; mult exception gives wbReg=30, wbData=4; div exception gives wbReg=30, wbData=5; timeout gives wbReg=30, wbData=6.
REQ-029 SHALL, for a normal result with rd==0, hold wbEnable=0 in the write cycle while keeping the same timing.
REQ-030 SHALL hold stall=1 in START, BUSY and DONE-blocked cycles.
REQ-031 SHALL make total stall cycles from issue = 2 + BUSY cycles to ready + DONE-blocked cycles.
REQ-032 SHALL allow back-to-back mult/div: a new isMD in the IDLE cycle after a write issues immediately.
REQ-033 SHALL hold mdA and mdB stable from START until the next issue.

Reset
REQ-034 SHALL, while reset=1 at a clock edge, go to IDLE from any state, including mid-BUSY, discarding any pending result without writing.
REQ-035 SHALL, after reset, drive stall=0, ctrl_MULT=0, ctrl_DIV=0, wbEnable=0, busy=0, wbReg=0, wbData=0, mdA=0, mdB=0, counter=0 and timeout flag=0.
REQ-036 SHALL keep any data_resultRDY arriving in the cycle after reset from causing a write.

Verification
REQ-037 SHALL pass: mult rd=5, A=6, B=7, unit ready 3 BUSY cycles later with result 42, pipelineWE=0 -> one ctrl_MULT pulse; stall high 5 cycles; wbEnable=1, wbReg=5, wbData=42 for one cycle.
REQ-038 SHALL pass: div rd=3, data_exception=1 at ready -> wbReg=30, wbData=5, single write.
REQ-039 SHALL pass: result ready while pipelineWE=1 for 2 cycles -> DONE held 2 cycles with stall=1, then write on the third cycle.
REQ-040 SHALL pass: unit never asserts ready -> after 64 BUSY cycles write r30=6, then IDLE.
REQ-041 SHALL pass: reset asserted in the 2nd BUSY cycle -> IDLE next edge, no write even when ready follows, outputs at reset values.
REQ-042 SHALL pass: two consecutive mults with rd=0, then rd=7 -> first produces no write but retires; second issues the cycle after, pulses ctrl_MULT once and writes r7.
